// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg: shared pipeline constants and fetch FSM encoding
package rv32_pipe_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic        S_FETCH   = 1'b0;
    localparam logic        S_DROP    = 1'b1;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter and pending redirect target registers
module fetch_pc_reg
    import rv32_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_pc_load,
    input  logic [XLEN-1:0] i_pc_next,
    input  logic            i_redirect_load,
    input  logic [XLEN-1:0] i_redirect_next,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_redirect_pc
);
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_redirect_pc;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= RESET_PC;
            r_redirect_pc <= '0;
        end else begin
            if (i_pc_load) r_pc <= i_pc_next;
            if (i_redirect_load) r_redirect_pc <= i_redirect_next;
        end
    end
    assign o_pc          = r_pc;
    assign o_redirect_pc = r_redirect_pc;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage, owns the PC and the instruction-memory read port
module instruction_fetch_unit
    import rv32_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv32_pipe_pkg::NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_read,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_busywait,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus_4,
    output logic        o_fetch_bubble
);
    logic        r_state;
    logic        w_state_next;
    logic        w_fetch;
    logic        w_done;
    logic        w_take;
    logic        w_pc_load;
    logic        w_redirect_load;
    logic [31:0] w_target;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus_4;
    logic [31:0] w_pc_next;
    logic [31:0] w_redirect_pc;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_pc_load       (w_pc_load),
        .i_pc_next       (w_pc_next),
        .i_redirect_load (w_redirect_load),
        .i_redirect_next (w_target),
        .o_pc            (w_pc),
        .o_redirect_pc   (w_redirect_pc)
    );

    // A branch outranks a stall: the EX instruction is older than the stalled one in ID.
    always_comb begin
        w_fetch         = r_state == S_FETCH;
        w_done          = o_imem_read & ~i_imem_busywait;
        w_take          = w_fetch & ~i_branch_taken & ~i_stall & w_done;
        w_target        = i_branch_target & ~32'd3;
        w_pc_plus_4     = w_pc + 32'd4;
        w_pc_load       = w_fetch ? (i_branch_taken ? w_done : w_take) : w_done;
        w_pc_next       = i_branch_taken ? w_target : (w_fetch ? w_pc_plus_4 : w_redirect_pc);
        w_redirect_load = i_branch_taken & (~w_fetch | ~w_done);
        w_state_next    = w_fetch ? ((i_branch_taken & ~w_done) ? S_DROP : S_FETCH)
                                  : (w_done ? S_FETCH : S_DROP);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_FETCH;
        else          r_state <= w_state_next;
    end

    assign o_imem_read    = i_rst_n;
    assign o_imem_addr    = w_pc;
    assign o_pc           = w_pc;
    assign o_pc_plus_4    = w_pc_plus_4;
    assign o_instruction  = w_take ? i_imem_rdata : NOP_INSTR;
    assign o_fetch_bubble = ~i_rst_n | (w_fetch & ~i_branch_taken & (i_stall | ~w_done));
endmodule
